// File: rtl/bcd_disp_pkg.sv
// Shared constants for the BCD display scanner: segment patterns, anode codes and scan slots.
// Patterns are {g,f,e,d,c,b,a}, active-low. Anodes are active-low with bit 0 as the units digit.
package bcd_disp_pkg;

    localparam int N_SCAN = 4;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_UNITS  = 4'b1110;
    localparam logic [3:0] AN_TENS   = 4'b1101;
    localparam logic [3:0] AN_CARRY  = 4'b1011;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    typedef enum logic [1:0] {
        SLOT_UNITS = 2'd0,
        SLOT_TENS  = 2'd1,
        SLOT_CARRY = 2'd2,
        SLOT_BLANK = 2'd3
    } slot_e;

    function automatic logic nib_invalid(input logic [3:0] nib);
        return nib > 4'd9;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-low 7-segment decoder.
// Nibbles above 9 render as "E"; blank overrides everything with all segments off.
module bcd_to_7seg
    import bcd_disp_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_E;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (nibble)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_E;
            endcase
        end
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Latches a two-digit BCD result plus carry and scans it onto a 4-digit multiplexed display.
// Define BCD_LZB_EN to blank leading zeros in the tens and carry slots.
module bcd_display_scan
    import bcd_disp_pkg::*;
#(
    parameter int CLK_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ld,
    input  logic [7:0] bcd_in,
    input  logic       carry_in,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       err
);

    localparam int DIV_W = $clog2(CLK_DIV);

`ifdef BCD_LZB_EN
    localparam bit LZB_EN = 1'b1;
`else
    localparam bit LZB_EN = 1'b0;
`endif

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    slot_e            idx_q, idx_d;
    logic [7:0]       val_q, val_d;
    logic             cy_q, cy_d;
    logic             err_q, err_d;
    logic [6:0]       seg_q;
    logic [3:0]       an_q, an_d;
    logic             tick;
    logic [3:0]       dec_nib;
    logic             dec_blank;
    logic [6:0]       dec_seg;

    assign tick = (div_cnt_q == DIV_W'(CLK_DIV - 1));

    // ld has no back-pressure: a high ld is captured on every edge, and rst wins over it.
    always_comb begin
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        idx_d     = tick ? slot_e'(idx_q + 2'd1) : idx_q;
        val_d     = val_q;
        cy_d      = cy_q;
        err_d     = err_q;
        if (ld) begin
            val_d = bcd_in;
            cy_d  = carry_in;
            err_d = nib_invalid(bcd_in[7:4]) || nib_invalid(bcd_in[3:0]);
        end
    end

    always_comb begin
        dec_nib   = 4'd0;
        dec_blank = 1'b0;
        an_d      = AN_OFF;
        case (idx_q)
            SLOT_UNITS: begin
                dec_nib = val_q[3:0];
                an_d    = AN_UNITS;
            end
            SLOT_TENS: begin
                dec_nib   = val_q[7:4];
                dec_blank = LZB_EN && (val_q[7:4] == 4'd0) && !cy_q;
                an_d      = dec_blank ? AN_OFF : AN_TENS;
            end
            SLOT_CARRY: begin
                dec_nib   = {3'b000, cy_q};
                dec_blank = LZB_EN && !cy_q;
                an_d      = dec_blank ? AN_OFF : AN_CARRY;
            end
            default: begin
                dec_blank = 1'b1;
                an_d      = AN_OFF;
            end
        endcase
    end

    bcd_to_7seg u_dec (
        .nibble (dec_nib),
        .blank  (dec_blank),
        .seg    (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            idx_q     <= SLOT_UNITS;
            val_q     <= 8'h00;
            cy_q      <= 1'b0;
            err_q     <= 1'b0;
            seg_q     <= SEG_BLANK;
            an_q      <= AN_OFF;
        end else begin
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            val_q     <= val_d;
            cy_q      <= cy_d;
            err_q     <= err_d;
            seg_q     <= dec_seg;
            an_q      <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign err = err_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Self-checking bench for bcd_display_scan with CLK_DIV=4, using a time-based display model.
// The model derives the visible slot from the edge count since reset and the last loaded value.
module tb_bcd_display_scan;

    localparam int D = 4;

    logic       clk;
    logic       rst;
    logic       ld;
    logic [7:0] bcd_in;
    logic       carry_in;
    logic [6:0] seg;
    logic [3:0] an;
    logic       err;

    int n_vec  = 0;
    int n_miss = 0;

    int         k;
    logic [7:0] m_val;
    logic       m_cy;
    logic       m_err;
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic       e_err;

    logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    bcd_display_scan #(.CLK_DIV(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .ld       (ld),
        .bcd_in   (bcd_in),
        .carry_in (carry_in),
        .seg      (seg),
        .an       (an),
        .err      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] digit_pat(input int d);
        if (d > 9) return 7'b0000110;
        return pat[d];
    endfunction

    // Returns {an, seg} for slot s given the currently held value.
    function automatic logic [10:0] model_out(input int s);
        bit lzb;
        int tens, units;
`ifdef BCD_LZB_EN
        lzb = 1'b1;
`else
        lzb = 1'b0;
`endif
        tens  = int'(m_val[7:4]);
        units = int'(m_val[3:0]);
        case (s)
            0: return {4'b1110, digit_pat(units)};
            1: begin
                if (lzb && tens == 0 && !m_cy) return {4'b1111, 7'h7F};
                return {4'b1101, digit_pat(tens)};
            end
            2: begin
                if (lzb && !m_cy) return {4'b1111, 7'h7F};
                return {4'b1011, digit_pat(m_cy ? 1 : 0)};
            end
            default: return {4'b1111, 7'h7F};
        endcase
    endfunction

    // Drive one cycle, advance the model across the edge, then settle at the falling edge.
    task automatic clk_edge(input logic r, input logic l, input logic [7:0] b, input logic c);
        logic [10:0] o;
        rst = r; ld = l; bcd_in = b; carry_in = c;
        @(posedge clk);
        if (r) begin
            e_seg = 7'h7F; e_an = 4'hF;
            m_val = 8'h00; m_cy = 1'b0; m_err = 1'b0; k = 0;
        end else begin
            o = model_out((k / D) % 4);
            e_an = o[10:7]; e_seg = o[6:0];
            if (l) begin
                m_val = b; m_cy = c;
                m_err = (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
            end
            k++;
        end
        e_err = m_err;
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            clk_edge(1'b1, 1'b1, 8'h55, 1'b1);
            n_vec++;
            if ({seg, an, err} !== {7'h7F, 4'hF, 1'b0}) begin
                n_miss++;
                $display("FAIL reset_hold: seg/an/err got %b/%b/%b expected 1111111/1111/0", seg, an, err);
            end
        end
        clk_edge(1'b0, 1'b0, 8'h00, 1'b0);
        n_vec++;
        if ({seg, an, err} !== {7'b1000000, 4'b1110, 1'b0}) begin
            n_miss++;
            $display("FAIL reset_release: seg/an/err got %b/%b/%b expected 1000000/1110/0", seg, an, err);
        end
    endtask

    // Load a value aligned to the start of a full scan frame and watch every cycle of it.
    task automatic test_pattern(input logic [7:0] b, input logic c);
        while ((k % (4 * D)) != (4 * D - 1)) clk_edge(1'b0, 1'b0, 8'h00, 1'b0);
        clk_edge(1'b0, 1'b1, b, c);
        for (int i = 0; i < 4 * D; i++) begin
            clk_edge(1'b0, 1'b0, 8'h00, 1'b0);
            n_vec++;
            if ({seg, an, err} !== {e_seg, e_an, e_err}) begin
                n_miss++;
                $display("FAIL pattern_%h_%0d cyc%0d: seg/an/err got %b/%b/%b expected %b/%b/%b",
                         b, c, i, seg, an, err, e_seg, e_an, e_err);
            end
        end
    endtask

    task automatic test_error();
        clk_edge(1'b0, 1'b1, 8'h1A, 1'b0);
        n_vec++;
        if (err !== 1'b1) begin
            n_miss++;
            $display("FAIL error_set: err got %b expected 1", err);
        end
        for (int i = 0; i < 4 * D; i++) begin
            clk_edge(1'b0, 1'b0, 8'h00, 1'b0);
            n_vec++;
            if ({seg, an, err} !== {e_seg, e_an, e_err}) begin
                n_miss++;
                $display("FAIL error_scan cyc%0d: seg/an/err got %b/%b/%b expected %b/%b/%b",
                         i, seg, an, err, e_seg, e_an, e_err);
            end
        end
        clk_edge(1'b0, 1'b1, 8'h09, 1'b0);
        n_vec++;
        if (err !== 1'b0) begin
            n_miss++;
            $display("FAIL error_clear: err got %b expected 0", err);
        end
    endtask

    task automatic test_ld_on_tick();
        for (int j = 0; j < 6; j++) begin
            while ((k % D) != (D - 1)) clk_edge(1'b0, 1'b0, 8'h00, 1'b0);
            clk_edge(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            for (int i = 0; i < D + 1; i++) begin
                clk_edge(1'b0, 1'b0, 8'h00, 1'b0);
                n_vec++;
                if ({seg, an, err} !== {e_seg, e_an, e_err}) begin
                    n_miss++;
                    $display("FAIL ld_on_tick %0d/%0d: seg/an/err got %b/%b/%b expected %b/%b/%b",
                             j, i, seg, an, err, e_seg, e_an, e_err);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        for (int i = 0; i < 400; i++) begin
            b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                            : {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            clk_edge(1'b0, 1'($urandom_range(0, 3) == 0), b, 1'($urandom_range(0, 1)));
            n_vec++;
            if ({seg, an, err} !== {e_seg, e_an, e_err}) begin
                n_miss++;
                $display("FAIL random cyc%0d: seg/an/err got %b/%b/%b expected %b/%b/%b",
                         i, seg, an, err, e_seg, e_an, e_err);
            end
        end
    endtask

    task automatic test_rst_mid_scan();
        clk_edge(1'b0, 1'b1, 8'h42, 1'b1);
        while (((k / D) % 4) != 2) clk_edge(1'b0, 1'b0, 8'h00, 1'b0);
        clk_edge(1'b1, 1'b1, 8'h99, 1'b1);
        n_vec++;
        if ({seg, an, err} !== {7'h7F, 4'hF, 1'b0}) begin
            n_miss++;
            $display("FAIL rst_mid_scan: seg/an/err got %b/%b/%b expected 1111111/1111/0", seg, an, err);
        end
        for (int i = 0; i < 4 * D; i++) begin
            clk_edge(1'b0, 1'b0, 8'h00, 1'b0);
            n_vec++;
            if ({seg, an, err} !== {e_seg, e_an, e_err}) begin
                n_miss++;
                $display("FAIL rst_restart cyc%0d: seg/an/err got %b/%b/%b expected %b/%b/%b",
                         i, seg, an, err, e_seg, e_an, e_err);
            end
        end
        n_vec++;
        if (m_val !== 8'h00 || dut.val_q !== 8'h00) begin
            n_miss++;
            $display("FAIL rst_drops_ld: val got %h expected 00", dut.val_q);
        end
    endtask

    initial begin
        rst = 1'b1; ld = 1'b0; bcd_in = 8'h00; carry_in = 1'b0;
        k = 0; m_val = 8'h00; m_cy = 1'b0; m_err = 1'b0;
        test_reset();
        test_pattern(8'h15, 1'b0);
        test_pattern(8'h18, 1'b1);
        test_pattern(8'h07, 1'b0);
        test_pattern(8'h90, 1'b0);
        test_error();
        test_ld_on_tick();
        test_random();
        test_rst_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/bcd_display_scan.md
# bcd_display_scan

Downstream display stage for the BCD adder: latches the adder's two-digit BCD result and carry on a load strobe and drives a 4-digit multiplexed 7-segment display. A clock divider generates a refresh tick, and a scan counter cycles through the digit anodes. Each digit's segment pattern is decoded from the latched value. Invalid BCD nibbles are flagged and shown as "E".

## Interface
- CLK_DIV, default 50000: system clocks per digit slot; legal range ≥ 2.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ld  in  1  load strobe; captures `bcd_in` and `carry_in` on the same edge.
- bcd_in  in  8  BCD value from the adder's `saida`; [7:4] tens, [3:0] units.
- carry_in  in  1  adder `carry`; displayed as the hundreds digit.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an  out  4  digit anodes, active-low; an[0] is units.
- err  out  1  latched value contains a nibble > 9.

## Operation
- Value register (`val`, `cy`) is loaded when `ld`=1; otherwise it holds. No back-pressure; `ld` is accepted every cycle.
- `err` is set on a load where either nibble > 9, and cleared on a load where both nibbles ≤ 9.
- Divider `div_cnt` counts 0..CLK_DIV-1 and wraps. `tick` is asserted while `div_cnt`=CLK_DIV-1.
- Scan index `idx` (2 bits) increments on `tick` and wraps 3→0.
- Per-slot content:
  - idx0: units nibble; never blanked.
  - idx1: tens nibble.
  - idx2: `cy` shown as digit 0/1.
  - idx3: always blank, with all anodes off (an=4'b1111).
- Decoding:
  - 0–9 use standard patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Nibble > 9 shows E=0000110.
  - Blank is 1111111, with the slot's anode deasserted.
- In slots 0–2, exactly one anode is low.

## Timing
- Reset values: seg=7'h7F, an=4'hF, err=0, val=0, cy=0, div_cnt=0, idx=0.
- `seg` and `an` are registered from `idx`, `val` and `cy`, giving 1 cycle of latency.
- First edge after rst falls: an=1110, seg=1000000.
- `idx` changes on the edge where `tick`=1. `an`/`seg` reflect the new slot one edge later.
- A load becomes visible on `seg` one edge after the capture edge.
- `ld` coincident with `tick`: both take effect. The newly loaded value is used for the next slot.
- `rst` asserted mid-scan: all state returns to reset values on that edge; any pending `ld` is dropped.

## Configuration
- Macro: BCD_LZB_EN (leading-zero blanking).
- Defined:
  - Slot 2 is blank when `cy`=0.
  - Slot 1 is blank when tens=0 and `cy`=0.
  - Blanked slots drive seg=7'h7F and keep their anode high.
- Undefined: slots 1 and 2 always display, including zeros.

## Structure
- Package `bcd_disp_pkg` holds:
  - segment constants SEG_0..SEG_9, SEG_E, SEG_BLANK;
  - N_SCAN=4;
  - anode one-hot constants.
- Sub-module `bcd_to_7seg`: combinational decoder with inputs nibble[3:0] and blank, output seg[6:0]. It is instantiated once, with its input muxed by `idx`.
- Top module holds the divider, scan counter, value register and output registers.

## Test plan
All scenarios run with CLK_DIV=4.
- Reset held 3 cycles, then released → seg=7F, an=F during reset; an=1110, seg=1000000 on the first edge after release; err=0.
- ld with bcd_in=8'h15, carry_in=0, BCD_LZB_EN undefined → scan shows an=1110/seg=0010010 (5), an=1101/seg=1111001 (1), an=1011/seg=1000000 (0), then an=1111/seg=7F. Each slot lasts 4 cycles.
- ld with bcd_in=8'h18, carry_in=1 → slot2 seg=1111001 (1); slot1 seg=1111001 (1); slot0 seg=0000000 (8).
- BCD_LZB_EN defined, ld with bcd_in=8'h07, carry_in=0 → slot0 seg=1111000 (7); slots 1 and 2 give an=1111, seg=7F.
- ld with bcd_in=8'h1A → err=1 and slot0 seg=0000110 (E). A following ld of 8'h09 → err=0 on the next edge.
- rst pulsed for 1 cycle while idx=2, with ld asserted on the same edge → an=F, seg=7F, and val stays 0. The scan restarts at slot0 with digit 0.
